// File: rtl/branch_recovery_queue_pkg.sv
// Shared defaults and FSM encoding for the branch recovery queue.
package branch_recovery_queue_pkg;

  localparam int BRQ_DEPTH = 4;
  localparam int BRQ_PC_W  = 16;
  localparam int BRQ_TAG_W = 2;
  localparam int STATS_W   = 16;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_REDIRECT = 1'b1
  } brq_state_e;

endpackage

// File: rtl/branch_recovery_queue_ptr_ctrl.sv
// Head/tail/count bookkeeping for the branch recovery queue, plus the
// younger-than-flush-tag kill mask (age = (tag - head) mod DEPTH).
module brq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alloc_n_i,
  input  logic [1:0]       ret_n_i,
  input  logic             flush_i,
  input  logic [TAG_W-1:0] flush_tag_i,
  output logic [TAG_W-1:0] head_o,
  output logic [TAG_W-1:0] tail_o,
  output logic [TAG_W:0]   count_o,
  output logic [DEPTH-1:0] kill_mask_o
);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [TAG_W-1:0] flush_age;
  logic [TAG_W-1:0] entry_age;

  // Kill mask is kept apart from the next-state logic so retire can use it
  // without forming a loop through ret_n_i.
  always_comb begin
    // NOTE: always_comb uses blocking assignments with every output given a default first, so no latch is inferred.
    kill_mask_o = '0;
    entry_age   = '0;
    flush_age   = flush_tag_i - head_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_age      = TAG_W'(i) - head_q;
      kill_mask_o[i] = flush_i && (entry_age > flush_age);
    end
  end

  always_comb begin
    head_d = head_q + TAG_W'(ret_n_i);
    if (flush_i) begin
      tail_d  = flush_tag_i + TAG_W'(1);
      count_d = {1'b0, flush_tag_i - head_q} + (TAG_W+1)'(1) - (TAG_W+1)'(ret_n_i);
    end else begin
      tail_d  = tail_q + TAG_W'(alloc_n_i);
      count_d = count_q + (TAG_W+1)'(alloc_n_i) - (TAG_W+1)'(ret_n_i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

endmodule

// File: rtl/branch_recovery_queue.sv
// In-order branch recovery queue: allocates up to 2 branches/cycle, resolves by tag,
// redirects and flushes younger entries on mispredict. Optional BRQ_STATS_EN adds mispred_cnt.
module branch_recovery_queue
  import branch_recovery_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int PC_W  = BRQ_PC_W,
  parameter int TAG_W = BRQ_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_vld0,
  input  logic             alloc_vld1,
  input  logic             alloc_tkn0,
  input  logic             alloc_tkn1,
  input  logic [PC_W-1:0]  alloc_recv_pc0,
  input  logic [PC_W-1:0]  alloc_recv_pc1,
  output logic             alloc_rdy,
  output logic [TAG_W-1:0] alloc_tag0,
  output logic [TAG_W-1:0] alloc_tag1,
  input  logic             rslv_vld,
  input  logic [TAG_W-1:0] rslv_tag,
  input  logic             rslv_tkn,
  output logic             redirect_vld,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [TAG_W-1:0] flush_tag,
  output logic             brq_empty
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0]      mispred_cnt
`endif
);

  localparam logic [TAG_W:0] ALLOC_MAX = (TAG_W+1)'(DEPTH - 2);

  brq_state_e       state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [DEPTH-1:0] pred_tkn_q;
  logic [PC_W-1:0]  recv_pc_q [DEPTH];
  logic [PC_W-1:0]  redirect_pc_q;
  logic [TAG_W-1:0] flush_tag_q;

  logic [TAG_W-1:0] head, tail, head_p1, tail_p1;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] kill_mask;
  logic             rslv_ok, mispred;
  logic             do_alloc0, do_alloc1, ret0, ret1;
  logic [1:0]       alloc_n, ret_n;

  assign head_p1 = head + TAG_W'(1);
  assign tail_p1 = tail + TAG_W'(1);

  brq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .alloc_n_i   (alloc_n),
    .ret_n_i     (ret_n),
    .flush_i     (mispred),
    .flush_tag_i (rslv_tag),
    .head_o      (head),
    .tail_o      (tail),
    .count_o     (count),
    .kill_mask_o (kill_mask)
  );

  // A mispredict discards any allocation presented in the same cycle.
  always_comb begin
    rslv_ok   = rslv_vld && valid_q[rslv_tag];
    mispred   = rslv_ok && (rslv_tkn != pred_tkn_q[rslv_tag]);
    alloc_rdy = !rst && (state_q == ST_NORMAL) && (count <= ALLOC_MAX);
    do_alloc0 = alloc_vld0 && alloc_rdy && !mispred;
    do_alloc1 = do_alloc0 && alloc_vld1;
    alloc_n   = {1'b0, do_alloc0} + {1'b0, do_alloc1};
  end

  always_comb begin
    ret0  = valid_q[head] && resolved_q[head];
    ret1  = ret0 && valid_q[head_p1] && resolved_q[head_p1] && !kill_mask[head_p1];
    ret_n = {1'b0, ret0} + {1'b0, ret1};
  end

  always_comb begin
    valid_d    = valid_q & ~kill_mask;
    resolved_d = resolved_q & ~kill_mask;
    if (rslv_ok) resolved_d[rslv_tag] = 1'b1;
    if (ret0) begin
      valid_d[head]    = 1'b0;
      resolved_d[head] = 1'b0;
    end
    if (ret1) begin
      valid_d[head_p1]    = 1'b0;
      resolved_d[head_p1] = 1'b0;
    end
    if (do_alloc0) begin
      valid_d[tail]    = 1'b1;
      resolved_d[tail] = 1'b0;
    end
    if (do_alloc1) begin
      valid_d[tail_p1]    = 1'b1;
      resolved_d[tail_p1] = 1'b0;
    end
  end

  always_comb begin
    state_d      = mispred ? ST_REDIRECT : ST_NORMAL;
    redirect_vld = (state_q == ST_REDIRECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_NORMAL;
      valid_q       <= '0;
      resolved_q    <= '0;
      redirect_pc_q <= '0;
      flush_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      if (mispred) begin
        redirect_pc_q <= recv_pc_q[rslv_tag];
        flush_tag_q   <= rslv_tag;
      end
    end
  end

  // NOTE: payload storage has no reset; valid_q gates every read of it.
  always_ff @(posedge clk) begin
    if (do_alloc0) begin
      pred_tkn_q[tail] <= alloc_tkn0;
      recv_pc_q[tail]  <= alloc_recv_pc0;
    end
    if (do_alloc1) begin
      pred_tkn_q[tail_p1] <= alloc_tkn1;
      recv_pc_q[tail_p1]  <= alloc_recv_pc1;
    end
  end

  assign redirect_pc = redirect_pc_q;
  assign flush_tag   = flush_tag_q;
  assign brq_empty   = (count == '0);
  assign alloc_tag0  = tail;
  assign alloc_tag1  = tail_p1;

`ifdef BRQ_STATS_EN
  logic [STATS_W-1:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mispred_cnt_q <= '0;
    end else if (mispred && (mispred_cnt_q != '1)) begin
      mispred_cnt_q <= mispred_cnt_q + STATS_W'(1);
    end
  end

  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_recovery_queue.sv
// Directed bench for branch_recovery_queue: expected redirects are queued at
// resolve time and checked by an independent monitor on the falling edge.
module tb_branch_recovery_queue;

  typedef struct {
    logic [15:0] pc;
    logic [1:0]  tag;
  } redir_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_vld0 = 1'b0, alloc_vld1 = 1'b0;
  logic        alloc_tkn0 = 1'b0, alloc_tkn1 = 1'b0;
  logic [15:0] alloc_recv_pc0 = '0, alloc_recv_pc1 = '0;
  logic        alloc_rdy;
  logic [1:0]  alloc_tag0, alloc_tag1;
  logic        rslv_vld = 1'b0;
  logic [1:0]  rslv_tag = '0;
  logic        rslv_tkn = 1'b0;
  logic        redirect_vld;
  logic [15:0] redirect_pc;
  logic [1:0]  flush_tag;
  logic        brq_empty;
`ifdef BRQ_STATS_EN
  logic [15:0] mispred_cnt;
`endif

  int     total = 0;
  int     bad   = 0;
  redir_t sb[$];

  always #5 clk = ~clk;

  branch_recovery_queue dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_vld0     (alloc_vld0),
    .alloc_vld1     (alloc_vld1),
    .alloc_tkn0     (alloc_tkn0),
    .alloc_tkn1     (alloc_tkn1),
    .alloc_recv_pc0 (alloc_recv_pc0),
    .alloc_recv_pc1 (alloc_recv_pc1),
    .alloc_rdy      (alloc_rdy),
    .alloc_tag0     (alloc_tag0),
    .alloc_tag1     (alloc_tag1),
    .rslv_vld       (rslv_vld),
    .rslv_tag       (rslv_tag),
    .rslv_tkn       (rslv_tkn),
    .redirect_vld   (redirect_vld),
    .redirect_pc    (redirect_pc),
    .flush_tag      (flush_tag),
    .brq_empty      (brq_empty)
`ifdef BRQ_STATS_EN
    ,
    .mispred_cnt    (mispred_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    alloc_vld0 = 1'b0;
    alloc_vld1 = 1'b0;
    rslv_vld   = 1'b0;
  endtask

  task automatic alloc(input logic v1, input logic t0, input logic [15:0] p0,
                       input logic t1, input logic [15:0] p1);
    alloc_vld0     = 1'b1;
    alloc_vld1     = v1;
    alloc_tkn0     = t0;
    alloc_recv_pc0 = p0;
    alloc_tkn1     = t1;
    alloc_recv_pc1 = p1;
  endtask

  task automatic resolve(input logic [1:0] tag, input logic tkn);
    rslv_vld = 1'b1;
    rslv_tag = tag;
    rslv_tkn = tkn;
  endtask

  task automatic expect_redirect(input logic [15:0] pc, input logic [1:0] tag);
    redir_t e;
    e.pc  = pc;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every redirect pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (redirect_vld) begin
      if (sb.size() == 0) begin
        check("unexpected_redirect", 32'(redirect_pc), 32'hFFFF_FFFF);
      end else begin
        redir_t e;
        e = sb.pop_front();
        check("redirect_pc", 32'(redirect_pc), 32'(e.pc));
        check("flush_tag", 32'(flush_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    // 1: reset values, then a two-branch allocation
    tick();
    tick();
    check("rst_alloc_rdy", 32'(alloc_rdy), 0);
    check("rst_empty", 32'(brq_empty), 1);
    check("rst_redirect_vld", 32'(redirect_vld), 0);
    check("rst_redirect_pc", 32'(redirect_pc), 0);
    check("rst_flush_tag", 32'(flush_tag), 0);
    check("rst_tag0", 32'(alloc_tag0), 0);
    check("rst_tag1", 32'(alloc_tag1), 1);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 32'(alloc_rdy), 1);
    alloc(1'b1, 1'b0, 16'h0011, 1'b1, 16'h0020);
    check("t1_tag0", 32'(alloc_tag0), 0);
    check("t1_tag1", 32'(alloc_tag1), 1);
    tick();
    check("t1_rdy_cnt2", 32'(alloc_rdy), 1);
    check("t1_not_empty", 32'(brq_empty), 0);

    // 2: younger branch mispredicts -> one-cycle redirect to 0x0020
    resolve(2'd1, 1'b0);
    expect_redirect(16'h0020, 2'd1);
    tick();
    check("t2_rdy_in_redirect", 32'(alloc_rdy), 0);
    tick();
    check("t2_rdy_after", 32'(alloc_rdy), 1);
    check("t2_tail_kept", 32'(alloc_tag0), 2);
    resolve(2'd0, 1'b0);
    tick();
    check("t2_not_empty_yet", 32'(brq_empty), 0);
    tick();
    check("t2_empty_after_retire2", 32'(brq_empty), 1);

    // 3: older branch mispredicts -> younger killed, tail rewound
    do_reset();
    alloc(1'b1, 1'b0, 16'h0011, 1'b1, 16'h0020);
    tick();
    resolve(2'd0, 1'b1);
    expect_redirect(16'h0011, 2'd0);
    tick();
    check("t3_tail_rewound", 32'(alloc_tag0), 1);
    tick();
    resolve(2'd1, 1'b0);
    tick();
    tick();
    check("t3_empty", 32'(brq_empty), 1);
    check("t3_tail_same", 32'(alloc_tag0), 1);

    // 3b: second mispredict on an older entry during REDIRECT restarts it
    alloc(1'b1, 1'b1, 16'h0100, 1'b0, 16'h0200);
    check("t3b_tag0", 32'(alloc_tag0), 1);
    tick();
    resolve(2'd2, 1'b1);
    expect_redirect(16'h0200, 2'd2);
    tick();
    resolve(2'd1, 1'b0);
    expect_redirect(16'h0100, 2'd1);
    tick();
    check("t3b_still_redirect", 32'(redirect_vld), 1);
    tick();
    check("t3b_empty", 32'(brq_empty), 1);
    check("t3b_tail", 32'(alloc_tag0), 2);
`ifdef BRQ_STATS_EN
    check("t3b_mispred_cnt", 32'(mispred_cnt), 3);
`endif

    // 4: fill all four entries, resolve, retire two per cycle
    do_reset();
    alloc(1'b1, 1'b1, 16'h1000, 1'b1, 16'h1001);
    tick();
    alloc(1'b1, 1'b1, 16'h1002, 1'b1, 16'h1003);
    check("t4_tag2", 32'(alloc_tag0), 2);
    tick();
    check("t4_full_rdy", 32'(alloc_rdy), 0);
    alloc(1'b1, 1'b1, 16'h1004, 1'b1, 16'h1005);
    tick();
    check("t4_drop_tail", 32'(alloc_tag0), 0);
    resolve(2'd3, 1'b1);
    tick();
    resolve(2'd2, 1'b1);
    tick();
    resolve(2'd1, 1'b1);
    tick();
    check("t4_no_early_retire", 32'(alloc_rdy), 0);
    resolve(2'd0, 1'b1);
    tick();
    check("t4_not_empty", 32'(brq_empty), 0);
    tick();
    check("t4_rdy_cnt2", 32'(alloc_rdy), 1);
    check("t4_not_empty2", 32'(brq_empty), 0);
    tick();
    check("t4_empty", 32'(brq_empty), 1);

    // 5: six single alloc/resolve/retire rounds across the pointer wrap
    for (int r = 0; r < 6; r++) begin
      alloc(1'b0, r[0], 16'(16'h2000 + r), 1'b0, 16'h0);
      check($sformatf("t5_tag_r%0d", r), 32'(alloc_tag0), 32'(r % 4));
      tick();
      resolve(2'(r % 4), r[0]);
      tick();
      tick();
      check($sformatf("t5_empty_r%0d", r), 32'(brq_empty), 1);
    end

    // count 3 blocks allocation
    alloc(1'b1, 1'b0, 16'h0A0A, 1'b1, 16'h0B0B);
    check("t5_tag_pair", 32'(alloc_tag0), 2);
    tick();
    alloc(1'b0, 1'b0, 16'h0C0C, 1'b0, 16'h0);
    check("t5_tag_wrap", 32'(alloc_tag0), 0);
    tick();
    check("t5_cnt3_rdy", 32'(alloc_rdy), 0);

    // 6: reset asserted while in REDIRECT
    resolve(2'd3, 1'b0);
    expect_redirect(16'h0B0B, 2'd3);
    tick();
`ifdef BRQ_STATS_EN
    check("t6_mispred_cnt_pre", 32'(mispred_cnt), 1);
`endif
    rst = 1'b1;
    tick();
    check("t6_redirect_dropped", 32'(redirect_vld), 0);
    check("t6_empty", 32'(brq_empty), 1);
    check("t6_rdy_in_rst", 32'(alloc_rdy), 0);
    check("t6_tag0", 32'(alloc_tag0), 0);
`ifdef BRQ_STATS_EN
    check("t6_mispred_cnt", 32'(mispred_cnt), 0);
`endif
    rst = 1'b0;
    tick();
    check("t6_rdy_after", 32'(alloc_rdy), 1);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
